// File: rtl/hsv_core_pkg.sv
// Shared types for hsv_core: commit interface payload, commit FSM states,
// trap cause codes and the redirect bundle sent back to the frontend.
package hsv_core_pkg;

  typedef logic [31:0] word;
  typedef logic [4:0]  reg_addr;
  typedef logic [30:0] reg_mask;

  typedef struct packed {
    word pc;
  } common_t;

  typedef struct packed {
    word     next_pc;
    word     result;
    logic    jump;
    logic    trap;
    logic    writeback;
    common_t common;
  } commit_data_t;

  typedef enum logic {
    COMMIT_RUN,
    COMMIT_FLUSH
  } commit_state_t;

  typedef logic [3:0] trap_cause_t;

  localparam trap_cause_t TRAP_CAUSE_ILLEGAL    = 4'd2;
  localparam trap_cause_t TRAP_CAUSE_MISALIGNED = 4'd0;

  typedef struct packed {
    logic valid;
    logic trap;
    word  pc;
  } redirect_t;

  // One-hot scoreboard bit for a destination register; bits above the mask width drop out.
  function automatic reg_mask rd_onehot(input reg_addr rd);
    return reg_mask'(32'd1 << rd);
  endfunction

endpackage

// File: rtl/hsv_core_commit_retire_ctr.sv
// Free-running retired-instruction counter; wraps silently at 2^W.
module hsv_core_commit_retire_ctr
  #(
    parameter int W = 64
  )
  (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
  );

  logic [W-1:0] count_q;

  // Count one per retiring commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hsv_core_commit.sv
// Commit stage of hsv_core: applies writeback, scoreboard release, redirect,
// flush and retire count for each accepted commit. Wrong-path commits that
// arrive while the pipeline drains after a redirect are discarded.
module hsv_core_commit
  import hsv_core_pkg::*;
  #(
    parameter int unsigned FlushCycles         = 2,
    parameter trap_cause_t TrapCauseIllegal    = TRAP_CAUSE_ILLEGAL,
    parameter trap_cause_t TrapCauseMisaligned = TRAP_CAUSE_MISALIGNED
  )
  (
    input  logic                         clk_core,
    input  logic                         rst_core,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [$bits(commit_data_t)-1:0] in_data,
    input  logic [4:0]                   in_rd_addr,
    input  logic [31:0]                  trap_vector,
    output logic                         wr_en,
    output logic [4:0]                   wr_addr,
    output logic [31:0]                  wr_data,
    output logic [30:0]                  release_mask,
    output logic                         flush,
    output logic                         redirect_valid,
    output logic [31:0]                  redirect_pc,
    output logic                         trap_taken,
    output logic [31:0]                  mepc,
    output logic [3:0]                   mcause,
    output logic [63:0]                  retired
  );

  localparam int CntW = $clog2(FlushCycles + 1);

  commit_data_t  cd_p0;
  commit_state_t state, state_nxt;
  logic [CntW-1:0] cnt, cnt_nxt;
  logic ready_q;

  logic      acc_p0, run_p0, misalign_p0, take_trap_p0, retire_p0, wb_p0;
  redirect_t redir_p0;

  logic        wr_en_p1, flush_p1, trap_taken_p1, redirect_valid_p1;
  logic [4:0]  wr_addr_p1;
  logic [31:0] wr_data_p1, redirect_pc_p1, mepc_p1;
  reg_mask     release_p1;
  trap_cause_t mcause_p1;

  logic unused_tvec_lsb;
  assign unused_tvec_lsb = ^trap_vector[1:0];

  assign cd_p0    = commit_data_t'(in_data);
  assign in_ready = ready_q;

  // ---- stage p0: decode the incoming commit ----
  assign acc_p0       = in_valid & ready_q;
  assign run_p0       = acc_p0 & (state == COMMIT_RUN);
  assign misalign_p0  = cd_p0.jump & (cd_p0.next_pc[1:0] != 2'b00);
  assign take_trap_p0 = cd_p0.trap | misalign_p0;
  assign retire_p0    = run_p0 & ~take_trap_p0;
  assign wb_p0        = retire_p0 & cd_p0.writeback & (in_rd_addr != 5'd0);

  assign redir_p0.valid = run_p0 & (take_trap_p0 | cd_p0.jump);
  assign redir_p0.trap  = run_p0 & take_trap_p0;
  assign redir_p0.pc    = take_trap_p0 ? {trap_vector[31:2], 2'b00} : cd_p0.next_pc;

  // Next state: a redirect opens a drain window of FlushCycles cycles.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      COMMIT_RUN: begin
        if (redir_p0.valid) begin
          state_nxt = COMMIT_FLUSH;
          cnt_nxt   = CntW'(FlushCycles);
        end
      end
      COMMIT_FLUSH: begin
        cnt_nxt = cnt - CntW'(1);
        if (cnt == CntW'(1)) begin
          state_nxt = COMMIT_RUN;
        end
      end
      default: begin
        state_nxt = COMMIT_RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, drain counter and ready flag.
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      state   <= COMMIT_RUN;
      cnt     <= '0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      ready_q <= 1'b1;
    end
  end

  // ---- stage p1: registered architectural effects ----
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      wr_en_p1          <= 1'b0;
      wr_addr_p1        <= '0;
      wr_data_p1        <= '0;
      release_p1        <= '0;
      flush_p1          <= 1'b0;
      redirect_valid_p1 <= 1'b0;
      trap_taken_p1     <= 1'b0;
      redirect_pc_p1    <= '0;
      mepc_p1           <= '0;
      mcause_p1         <= '0;
    end else begin
      wr_en_p1          <= wb_p0;
      release_p1        <= wb_p0 ? rd_onehot(in_rd_addr) : '0;
      flush_p1          <= redir_p0.valid;
      redirect_valid_p1 <= redir_p0.valid;
      trap_taken_p1     <= redir_p0.trap;
      if (wb_p0) begin
        wr_addr_p1 <= in_rd_addr;
        wr_data_p1 <= cd_p0.result;
      end
      if (redir_p0.valid) begin
        redirect_pc_p1 <= redir_p0.pc;
      end
      if (redir_p0.trap) begin
        mepc_p1   <= cd_p0.common.pc;
        mcause_p1 <= cd_p0.trap ? TrapCauseIllegal : TrapCauseMisaligned;
      end
    end
  end

  hsv_core_commit_retire_ctr #(.W(64)) u_retire_ctr (
    .clk   (clk_core),
    .rst   (rst_core),
    .inc   (retire_p0),
    .count (retired)
  );

  assign wr_en          = wr_en_p1;
  assign wr_addr        = wr_addr_p1;
  assign wr_data        = wr_data_p1;
  assign release_mask   = release_p1;
  assign flush          = flush_p1;
  assign redirect_valid = redirect_valid_p1;
  assign trap_taken     = trap_taken_p1;
  assign redirect_pc    = redirect_pc_p1;
  assign mepc           = mepc_p1;
  assign mcause         = mcause_p1;

endmodule

// File: tb/tb_hsv_core_commit.sv
// Bench for hsv_core_commit: directed scenarios followed by random commits,
// every cycle compared against a behavioural model of the commit rules.
module tb_hsv_core_commit;
  import hsv_core_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  commit_data_t cd;
  logic [4:0]   rd;
  logic [31:0]  tvec;

  logic         in_ready, wr_en, flush, redirect_valid, trap_taken;
  logic [4:0]   wr_addr;
  logic [31:0]  wr_data, redirect_pc, mepc;
  logic [30:0]  release_mask;
  logic [3:0]   mcause;
  logic [63:0]  retired;

  int n_assert = 0;
  int n_fail   = 0;

  // model state
  logic        m_ready;
  int          m_drop;
  logic [63:0] m_retired;
  logic [31:0] m_mepc, m_rpc;
  logic [3:0]  m_mcause;
  logic        e_wr_en, e_flush, e_rv, e_tt;
  logic [4:0]  e_wr_addr;
  logic [31:0] e_wr_data;
  logic [30:0] e_rel;

  always #5 clk = ~clk;

  hsv_core_commit dut (
    .clk_core       (clk),
    .rst_core       (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (cd),
    .in_rd_addr     (rd),
    .trap_vector    (tvec),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .release_mask   (release_mask),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .trap_taken     (trap_taken),
    .mepc           (mepc),
    .mcause         (mcause),
    .retired        (retired)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply the commit rules to the inputs seen at this edge.
  task automatic model();
    logic mis;
    e_wr_en = 1'b0; e_flush = 1'b0; e_rv = 1'b0; e_tt = 1'b0; e_rel = '0;
    if (rst) begin
      m_ready = 1'b0; m_drop = 0; m_retired = '0;
      m_mepc = '0; m_rpc = '0; m_mcause = '0;
      e_wr_addr = '0; e_wr_data = '0;
    end else begin
      if (m_drop > 0) begin
        m_drop--;
      end else if (in_valid && m_ready) begin
        mis = cd.jump && (cd.next_pc % 4 != 0);
        if (cd.trap || mis) begin
          e_flush = 1'b1; e_rv = 1'b1; e_tt = 1'b1;
          m_rpc = tvec & 32'hFFFF_FFFC;
          m_mepc = cd.common.pc;
          m_mcause = cd.trap ? 4'd2 : 4'd0;
          m_drop = 2;
        end else begin
          m_retired = m_retired + 1;
          if (cd.writeback && rd != 0) begin
            e_wr_en = 1'b1; e_wr_addr = rd; e_wr_data = cd.result;
            e_rel = 31'(2 ** rd);
          end
          if (cd.jump) begin
            e_flush = 1'b1; e_rv = 1'b1;
            m_rpc = cd.next_pc;
            m_drop = 2;
          end
        end
      end
      m_ready = 1'b1;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model();
    chk("in_ready", 64'(in_ready), 64'(m_ready));
    chk("wr_en", 64'(wr_en), 64'(e_wr_en));
    if (e_wr_en) begin
      chk("wr_addr", 64'(wr_addr), 64'(e_wr_addr));
      chk("wr_data", 64'(wr_data), 64'(e_wr_data));
    end
    chk("release_mask", 64'(release_mask), 64'(e_rel));
    chk("flush", 64'(flush), 64'(e_flush));
    chk("redirect_valid", 64'(redirect_valid), 64'(e_rv));
    chk("trap_taken", 64'(trap_taken), 64'(e_tt));
    chk("redirect_pc", 64'(redirect_pc), 64'(m_rpc));
    chk("mepc", 64'(mepc), 64'(m_mepc));
    chk("mcause", 64'(mcause), 64'(m_mcause));
    chk("retired", retired, m_retired);
  endtask

  task automatic drive(input logic v, input logic tr, input logic jp, input logic wb,
                       input logic [4:0] rdv, input logic [31:0] res,
                       input logic [31:0] np, input logic [31:0] pc);
    in_valid = v;
    cd.trap = tr; cd.jump = jp; cd.writeback = wb;
    cd.result = res; cd.next_pc = np; cd.common.pc = pc;
    rd = rdv;
    cycle();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    cycle();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; cd = '0; rd = '0; tvec = 32'h0000_0203;
    m_ready = 1'b0; m_drop = 0; m_retired = '0; m_mepc = '0; m_rpc = '0; m_mcause = '0;
    cycle();
    cycle();
    chk("reset_ready", 64'(in_ready), 64'd0);
    chk("reset_retired", retired, 64'd0);
    rst = 1'b0;
    idle();
    chk("post_reset_ready", 64'(in_ready), 64'd1);

    // plain ALU writeback
    drive(1, 0, 0, 1, 5'd5, 32'hDEAD_BEEF, 32'h14, 32'h10);
    chk("alu_wr_data", 64'(wr_data), 64'hDEAD_BEEF);
    chk("alu_release", 64'(release_mask), 64'h20);
    chk("alu_retired", retired, 64'd1);

    // rd=0 retires without writing
    drive(1, 0, 0, 1, 5'd0, 32'h1234, 32'h18, 32'h14);
    chk("x0_wr_en", 64'(wr_en), 64'd0);
    chk("x0_retired", retired, 64'd2);

    // aligned jump, then two dropped commits and one that writes
    drive(1, 0, 1, 1, 5'd1, 32'h24, 32'h100, 32'h20);
    chk("jmp_redirect_pc", 64'(redirect_pc), 64'h100);
    drive(1, 0, 0, 1, 5'd7, 32'h77, 32'h0, 32'h24);
    drive(1, 0, 0, 1, 5'd8, 32'h88, 32'h0, 32'h28);
    drive(1, 0, 0, 1, 5'd9, 32'h99, 32'h0, 32'h100);
    chk("after_flush_wr_addr", 64'(wr_addr), 64'd9);

    // illegal trap
    drive(1, 1, 0, 1, 5'd3, 32'h33, 32'h44, 32'h40);
    chk("trap_mepc", 64'(mepc), 64'h40);
    chk("trap_rpc", 64'(redirect_pc), 64'h200);
    idle();
    idle();

    // misaligned jump
    drive(1, 0, 1, 1, 5'd4, 32'h54, 32'h102, 32'h50);
    chk("mis_mcause", 64'(mcause), 64'd0);
    idle();
    idle();

    // reset while draining
    drive(1, 0, 1, 1, 5'd2, 32'h64, 32'h200, 32'h60);
    rst = 1'b1;
    drive(1, 0, 0, 1, 5'd10, 32'hAA, 32'h0, 32'h204);
    rst = 1'b0;
    idle();
    drive(1, 0, 0, 1, 5'd6, 32'h66, 32'h0, 32'h300);
    chk("post_rst_retired", retired, 64'd1);

    // random commits
    for (int i = 0; i < 400; i++) begin
      logic [31:0] np;
      np = $urandom;
      if ($urandom_range(0, 3) != 0) np[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) tvec = $urandom;
      rst = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 30)), $urandom, np, $urandom);
    end
    rst = 1'b0;
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
